// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-in/byte-out bundle between the UART receiver, the rx FIFO and its consumer
//   uart_re/rd_data  receiver byte strobe and data
//   pop/ovf_clr      consumer read strobe and overflow clear
//   data_out/empty/full/count  FWFT head and fill state
//   overflow/thresh_irq/timeout_irq/rx_irq  status and interrupts
interface uart_rx_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic uart_re, pop, ovf_clr, empty, full, overflow, thresh_irq, timeout_irq, rx_irq;
  logic [7:0] rd_data, data_out;
  logic [DEPTH_LOG2:0] count;
  modport master(output uart_re, rd_data, pop, ovf_clr,
                 input data_out, empty, full, count, overflow, thresh_irq, timeout_irq, rx_irq);
  modport slave(input uart_re, rd_data, pop, ovf_clr,
                output data_out, empty, full, count, overflow, thresh_irq, timeout_irq, rx_irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer with sticky overflow, fill-threshold and idle-timeout interrupts
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_fifo_if.slave (receiver push side, consumer pop side, status/irqs)
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH = 8,
  parameter int TIMEOUT_CYCLES = 17360
) (
  input logic clk,
  input logic rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int D = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(D);
  localparam logic [DEPTH_LOG2:0] THR = (DEPTH_LOG2 + 1)'(THRESH);
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  logic [7:0] mem [D];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0] count, count_nx;
  logic [15:0] idle, idle_nx;
  logic overflow, overflow_nx, thresh, thresh_nx, timeout, timeout_nx, rx, push_ok, pop_ok;
  always_comb begin
    pop_ok = bus.pop && count != '0;
    // a full FIFO still takes the byte when the head leaves on the same edge
    push_ok = bus.uart_re && (count != FULL_CNT || pop_ok);
    count_nx = (push_ok && !pop_ok) ? count + 1'b1 : (pop_ok && !push_ok) ? count - 1'b1 : count;
    overflow_nx = (bus.uart_re && !push_ok) ? 1'b1 : bus.ovf_clr ? 1'b0 : overflow;
    idle_nx = (push_ok || pop_ok || count == '0) ? 16'd0 : (idle == TMO) ? idle : idle + 16'd1;
    thresh_nx = count_nx >= THR;
    timeout_nx = idle_nx == TMO && count_nx != '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      idle <= '0;
      thresh <= 1'b0;
      timeout <= 1'b0;
      rx <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      count <= count_nx;
      overflow <= overflow_nx;
      idle <= idle_nx;
      thresh <= thresh_nx;
      timeout <= timeout_nx;
      rx <= thresh_nx | timeout_nx;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= bus.rd_data;
  assign bus.data_out = (count == '0) ? 8'h00 : mem[rptr];
  assign bus.empty = count == '0;
  assign bus.full = count == FULL_CNT;
  assign bus.count = count;
  assign bus.overflow = overflow;
  assign bus.thresh_irq = thresh;
  assign bus.timeout_irq = timeout;
  assign bus.rx_irq = rx;
endmodule
